// File: rtl/pipe_fetch_queue.sv
// pipe_fetch_queue: instruction fetch front-end. Owns the fetch PC, keeps
// several memory reads in flight, buffers returned words in a small FIFO and
// flushes everything on a jump/branch redirect.
//
// Handshakes: a memory request transfers on a cycle where fetchEnable and
// fetchReady are both high. A response transfers on any cycle with
// fetchDataValid high (no back-pressure). An instruction is consumed on a
// cycle where instructionValid and instructionReady are both high.
// fetchEnable never depends on fetchReady, and instructionValid never depends
// on instructionReady.
module pipe_fetch_queue #(
  parameter logic [31:0] PROGRAM_COUNTER_RESET = 32'h0,
  parameter int          QUEUE_DEPTH           = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        jumpEnable,
  input  logic [31:0] jumpAddress,
  output logic [31:0] fetchAddress,
  output logic        fetchEnable,
  input  logic        fetchReady,
  input  logic        fetchDataValid,
  input  logic [31:0] fetchData,
  output logic        instructionValid,
  input  logic        instructionReady,
  output logic [31:0] instruction,
  output logic [31:0] instructionProgramCounter,
  output logic        addressMisaligned
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(QUEUE_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   response_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] occupancy;
  logic          halted;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic [31:0]   data_mem  [QUEUE_DEPTH];
  logic [31:0]   pc_mem    [QUEUE_DEPTH];
  logic          fault_mem [QUEUE_DEPTH];

  logic [CW:0]   committed;
  logic          has_space;
  logic          aligned;
  logic          req_fire;
  logic          resp_stale;
  logic          resp_push;
  logic          fault_push;
  logic          push;
  logic          pop;
  logic [31:0]   push_data;
  logic [31:0]   push_pc;

  // Space counts buffered plus live in-flight requests; stale (discarded)
  // requests never land in the FIFO, so they do not hold back a redirect.
  assign committed = {1'b0, occupancy} + {1'b0, outstanding};
  assign has_space = committed < DEPTH_EXT;
  assign aligned   = (fetch_pc[1:0] == 2'b00);

  // Gated by rst_n so the request strobe drops the instant reset asserts,
  // even though enable may still be high.
  assign fetchEnable  = rst_n & enable & ~jumpEnable & ~halted & aligned & has_space;
  assign fetchAddress = fetch_pc;

  assign req_fire   = fetchEnable & fetchReady;
  assign resp_stale = fetchDataValid & (discard != '0);
  assign resp_push  = fetchDataValid & (discard == '0) & ~jumpEnable;
  // A misaligned PC is reported only once the pipe is quiet, so the fault
  // entry lands after every older instruction.
  assign fault_push = ~jumpEnable & ~halted & ~aligned &
                      (occupancy == '0) & (outstanding == '0);
  assign push       = resp_push | fault_push;
  assign pop        = instructionValid & instructionReady & ~jumpEnable;

  assign push_data  = resp_push ? fetchData : 32'h0;
  assign push_pc    = resp_push ? response_pc : fetch_pc;

  assign instructionValid          = (occupancy != '0);
  assign instruction               = data_mem[rd_ptr];
  assign instructionProgramCounter = pc_mem[rd_ptr];
  assign addressMisaligned         = fault_mem[rd_ptr];

  // PCs, request accounting, halt flag and FIFO pointers; a jump overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= PROGRAM_COUNTER_RESET;
      response_pc <= PROGRAM_COUNTER_RESET;
      outstanding <= '0;
      discard     <= '0;
      occupancy   <= '0;
      halted      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (jumpEnable) begin
      fetch_pc    <= jumpAddress;
      response_pc <= jumpAddress;
      outstanding <= '0;
      // Every request still owed becomes stale. A response arriving right
      // now retires one of them, whichever pool it belonged to.
      discard     <= discard + outstanding - CW'(fetchDataValid);
      occupancy   <= '0;
      halted      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp_push) begin
        response_pc <= response_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_push);
      if (resp_stale) begin
        discard <= discard - 1'b1;
      end
      if (fault_push) begin
        halted <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occupancy <= occupancy + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: write the pushed entry at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        data_mem[i]  <= '0;
        pc_mem[i]    <= '0;
        fault_mem[i] <= 1'b0;
      end
    end else if (push) begin
      data_mem[wr_ptr]  <= push_data;
      pc_mem[wr_ptr]    <= push_pc;
      fault_mem[wr_ptr] <= fault_push & ~resp_push;
    end
  end

endmodule
